wb_sched: RTL
=============

WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset, with ports named `clock` and `rst`.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  system clock; rising edge active
- rst  in  1  asynchronous active-low reset
- jal_req  in  1  link-write request; destination is register 31
- jal_data  in  32  link value (pc+4)
- mem_req  in  1  load-return valid; non-stallable
- mem_dst  in  5  load destination register
- mem_data  in  32  load data
- alu_req  in  1  ALU-result write request
- alu_dst  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- issue_valid  in  1  a load was issued this cycle
- issue_dst  in  5  destination of the issued load
- query_rs  in  5  hazard-query address
- query_rt  in  5  hazard-query address
- rs_busy  out  1  query_rs has a load pending
- rt_busy  out  1  query_rt has a load pending
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  5  write address, registered
- rf_wdata  out  32  write data, registered
- mem_ovf  out  1  sticky load-buffer overflow flag
- stall_cnt  out  16  saturating count of ALU stall cycles

Function
REQ-003 The block SHALL contain a 2-entry FIFO for load returns; every mem_req SHALL push {mem_dst, mem_data} into it, with no bypass.
REQ-004 The candidates for the single write port each cycle SHALL be jal_req, the FIFO head (when the FIFO is non-empty) and alu_req, with fixed priority jal > FIFO head > alu.
REQ-005 Exactly one candidate SHALL be granted per cycle, and the grant SHALL go to the highest-priority asserted candidate.
REQ-006 A FIFO-head grant SHALL pop the FIFO in the same cycle.
REQ-007 alu_ready SHALL be combinational and equal to alu_req AND NOT jal_req AND FIFO empty.
REQ-008 A stalled ALU request SHALL be held by the upstream stage; the block SHALL NOT store it.
REQ-009 jal_req SHALL always be granted in its request cycle.
REQ-010 Write latency: the granted write SHALL appear on rf_we/rf_waddr/rf_wdata on the clock edge following the grant.
REQ-011 rf_we SHALL be high for exactly one cycle per grant.
REQ-012 With no grant, rf_we SHALL be 0, and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-013 A granted request whose destination is 0 SHALL be consumed (popped or accepted) with rf_we = 0.
REQ-014 FIFO push and pop in the same cycle SHALL both take effect; a push to a full FIFO that pops in the same cycle SHALL be accepted.
REQ-015 A push to a full FIFO with no pop SHALL be dropped and SHALL set mem_ovf.
REQ-016 mem_ovf SHALL clear only on reset.
REQ-017 The FIFO read and write pointers SHALL wrap modulo 2; order SHALL be preserved.
REQ-018 Scoreboard: the block SHALL keep a 32-bit pending vector.
REQ-019 issue_valid with issue_dst != 0 SHALL set pending[issue_dst] at the clock edge.
REQ-020 A FIFO-head grant with dst d SHALL clear pending[d] at the same edge on which rf_we rises.
REQ-021 When a set and a clear target the same register on the same edge, the set SHALL win.
REQ-022 Re-issuing to an already-pending register SHALL leave its pending bit at 1.
REQ-023 pending[0] SHALL be constant 0.
REQ-024 rs_busy SHALL be pending[query_rs] and rt_busy SHALL be pending[query_rt], both combinational.
REQ-025 stall_cnt SHALL increment on each cycle with alu_req = 1 and alu_ready = 0, and SHALL saturate at 16'hFFFF.

Reset
REQ-026 On rst = 0 the block SHALL asynchronously set rf_we = 0, rf_waddr = 0, rf_wdata = 0, FIFO empty (both pointers 0), pending = 0, mem_ovf = 0 and stall_cnt = 0.
REQ-027 During reset, alu_ready SHALL be 0.
REQ-028 rs_busy and rt_busy SHALL be 0 during reset.
REQ-029 Reset mid-operation SHALL discard FIFO contents and pending bits, and no write SHALL be emitted on the first edge after reset deassertion.
REQ-030 Reset deassertion SHALL be taken synchronously to the clock, on the next rising edge.

Verification
REQ-031 Scenario, ALU write: alu_req = 1, dst = 5, data = 32'h1234, no other request -> alu_ready = 1; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 32'h1234.
REQ-032 Scenario, three-way conflict: jal_req (data 32'h0040_0008), mem_req (dst 8, data 32'hAA) and alu_req (dst 9) in the same cycle -> writes in order r31 = 32'h0040_0008, then r8 = 32'hAA, then r9; ALU stalls for 2 cycles and stall_cnt = 2.
REQ-033 Scenario, FIFO overflow: 3 consecutive mem_req cycles with jal_req held high -> the third load is dropped, mem_ovf = 1, and exactly 2 loads are written after jal drops.
REQ-034 Scenario, scoreboard: issue_valid with dst 7, then query_rs = 7 -> rs_busy = 1 until the edge where the load to r7 writes, then 0; a re-issue of r7 on that same edge -> rs_busy stays 1.
REQ-035 Scenario, register 0: mem_req with dst 0 and alu_req with dst 0 -> both consumed, rf_we never 1, and the pending vector is unchanged.
REQ-036 Scenario, reset mid-operation: assert rst with the FIFO holding 2 entries -> all outputs reach their reset values immediately; after release, no write occurs until a new request arrives.

Source files
------------

// File: rtl/wb_sched.sv
// wb_sched: arbitrates the single register-file write port between jal link writes,
// buffered load returns and ALU results, and tracks outstanding loads in a scoreboard.
module wb_sched (
    input  logic        clock,
    input  logic        rst,
    input  logic        jal_req,
    input  logic [31:0] jal_data,
    input  logic        mem_req,
    input  logic [4:0]  mem_dst,
    input  logic [31:0] mem_data,
    input  logic        alu_req,
    input  logic [4:0]  alu_dst,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dst,
    input  logic [4:0]  query_rs,
    input  logic [4:0]  query_rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mem_ovf,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {GNT_NONE, GNT_JAL, GNT_MEM, GNT_ALU} grant_t;

    logic        rst_sync;
    logic [4:0]  fifo_dst  [2];
    logic [31:0] fifo_data [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    grant_t      grant;
    logic [4:0]  win_dst;
    logic [31:0] win_data;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    // Reset asserts immediately but releases on the next rising edge, so the
    // first edge after release is spent leaving reset and emits no write.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rst_sync <= 1'b0;
        end else begin
            rst_sync <= 1'b1;
        end
    end

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        grant    = GNT_NONE;
        win_dst  = '0;
        win_data = '0;
        if (jal_req) begin
            grant    = GNT_JAL;
            win_dst  = 5'd31;
            win_data = jal_data;
        end else if (!fifo_empty) begin
            grant    = GNT_MEM;
            win_dst  = fifo_dst[rd_ptr];
            win_data = fifo_data[rd_ptr];
        end else if (alu_req) begin
            grant    = GNT_ALU;
            win_dst  = alu_dst;
            win_data = alu_data;
        end
    end

    assign alu_ready = rst_sync & alu_req & ~jal_req & fifo_empty;
    assign pop       = (grant == GNT_MEM);
    assign push      = mem_req & (~fifo_full | pop);

    // NOTE: the FIFO storage has no reset; fifo_cnt alone says which slots are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_dst[wr_ptr]  <= mem_dst;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            mem_ovf  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if (mem_req && !push) mem_ovf <= 1'b1;
        end
    end

    // Issue is applied after the load-return clear so a same-edge re-issue keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (pop)         pending_nxt[win_dst]   = 1'b0;
        if (issue_valid) pending_nxt[issue_dst] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            pending   <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            stall_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            rf_we   <= (grant != GNT_NONE) && (win_dst != 5'd0);
            if (grant != GNT_NONE) begin
                rf_waddr <= win_dst;
                rf_wdata <= win_data;
            end
            if (alu_req && !alu_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign rs_busy = pending[query_rs];
    assign rt_busy = pending[query_rt];

endmodule
